// File: rtl/dsp_post_stage_pkg.sv
// dsp_post_stage_pkg: widths, OPMODE fields and select encodings for the DSP post stage.
package dsp_post_stage_pkg;
  localparam int D_W = 12;
  localparam int AB_W = 18;
  localparam int M_W = 2 * AB_W;
  localparam int P_W = D_W + 2 * AB_W;
  localparam int OPM_X = 0;
  localparam int OPM_Z = 2;
  localparam int OPM_CIN = 5;
  localparam int OPM_SUB = 7;
  localparam logic [1:0] X_ZERO = 2'd0;
  localparam logic [1:0] X_M = 2'd1;
  localparam logic [1:0] X_P = 2'd2;
  localparam logic [1:0] X_CONCAT = 2'd3;
  localparam logic [1:0] Z_ZERO = 2'd0;
  localparam logic [1:0] Z_PCIN = 2'd1;
  localparam logic [1:0] Z_P = 2'd2;
  localparam logic [1:0] Z_C = 2'd3;
  localparam string CIN_OPMODE5 = "OPMODE5";
  localparam string CIN_CARRYIN = "CARRYIN";
endpackage

// File: rtl/dsp_post_stage_reg_mux.sv
// dsp_post_stage_reg_mux: optional register with clock enable and reset, or transparent bypass.
module dsp_post_stage_reg_mux #(
  parameter int WIDTH = 1,
  parameter int REG = 1,
  parameter string RSTTYPE = "SYNC"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r;
  if (RSTTYPE == "ASYNC") begin : g_async
    always_ff @(posedge clk or posedge rst)
      if (rst) r <= '0;
      else if (ce) r <= d;
  end else begin : g_sync
    always_ff @(posedge clk)
      if (rst) r <= '0;
      else if (ce) r <= d;
  end
  assign q = (REG != 0) ? r : d;
endmodule

// File: rtl/dsp_post_stage.sv
// dsp_post_stage: X/Z operand muxes and 48-bit post add/subtract with carry, optional M/P/CYI/OPMODE registers.
module dsp_post_stage
  import dsp_post_stage_pkg::*;
#(
  parameter int MREG = 1,
  parameter int PREG = 1,
  parameter int CARRYINREG = 1,
  parameter int OPMODEREG = 1,
  parameter string CARRYINSEL = CIN_OPMODE5
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           CEM,
  input  logic           CEP,
  input  logic           CECARRYIN,
  input  logic           CEOPMODE,
  input  logic [7:0]     OPMODE,
  input  logic [M_W-1:0] M_IN,
  input  logic [P_W-1:0] CONCAT,
  input  logic [P_W-1:0] C_IN,
  input  logic [P_W-1:0] PCIN,
  input  logic           CARRYIN,
  output logic [M_W-1:0] M,
  output logic [P_W-1:0] P,
  output logic [P_W-1:0] PCOUT,
  output logic           CARRYOUT,
  output logic           CARRYOUTF
);
  logic [7:0] op;
  logic cin_sel, cin, unused_op;
  logic [P_W-1:0] x, z, p_fb;
  logic [P_W:0] res, pq;
  dsp_post_stage_reg_mux #(.WIDTH(8), .REG(OPMODEREG)) u_opmode (
    .clk(CLK), .rst(RST), .ce(CEOPMODE), .d(OPMODE), .q(op));
  dsp_post_stage_reg_mux #(.WIDTH(M_W), .REG(MREG)) u_m (
    .clk(CLK), .rst(RST), .ce(CEM), .d(M_IN), .q(M));
  assign cin_sel = (CARRYINSEL == CIN_CARRYIN) ? CARRYIN : op[OPM_CIN];
  dsp_post_stage_reg_mux #(.WIDTH(1), .REG(CARRYINREG)) u_cyi (
    .clk(CLK), .rst(RST), .ce(CECARRYIN), .d(cin_sel), .q(cin));
  assign unused_op = ^{op[6], op[4], CARRYIN};
  // Without a P register the feedback path would be a combinational loop, so it reads as zero.
  assign p_fb = (PREG != 0) ? P : '0;
  always_comb begin
    x = '0;
    z = '0;
    case (op[OPM_X+:2])
      X_ZERO:   x = '0;
      X_M:      x = {{(P_W-M_W){1'b0}}, M};
      X_P:      x = p_fb;
      X_CONCAT: x = CONCAT;
    endcase
    case (op[OPM_Z+:2])
      Z_ZERO: z = '0;
      Z_PCIN: z = PCIN;
      Z_P:    z = p_fb;
      Z_C:    z = C_IN;
    endcase
  end
  assign res = op[OPM_SUB] ? {1'b0, z} - ({1'b0, x} + {{P_W{1'b0}}, cin})
                           : {1'b0, z} + {1'b0, x} + {{P_W{1'b0}}, cin};
  dsp_post_stage_reg_mux #(.WIDTH(P_W+1), .REG(PREG)) u_p (
    .clk(CLK), .rst(RST), .ce(CEP), .d(res), .q(pq));
  assign P = pq[P_W-1:0];
  assign CARRYOUT = pq[P_W];
  assign PCOUT = P;
  assign CARRYOUTF = CARRYOUT;
endmodule

// File: tb/tb_dsp_post_stage.sv
// tb_dsp_post_stage: bypass vector table plus registered pipeline, accumulate and carry sequences.
module tb_dsp_post_stage;
  logic CLK = 0, RST = 1, CEM = 1, CEP = 1, CECARRYIN = 1, CEOPMODE = 1, CARRYIN = 0;
  logic [7:0] OPMODE = 0;
  logic [35:0] M_IN = 0;
  logic [47:0] CONCAT = 0, C_IN = 0, PCIN = 0;
  logic [35:0] m [5];
  logic [47:0] p [5];
  logic [47:0] pc [5];
  logic co [5];
  logic cof [5];
  int n = 0, err = 0;
  typedef struct {
    logic [7:0] op;
    logic [35:0] mi;
    logic [47:0] c, cc, pci;
    logic ep_unused;
    logic [47:0] ep;
    logic eco;
  } vec_t;
  vec_t tbl [10];
  always #5 CLK = ~CLK;
  // a: all registers, b: carry from CARRYIN port, c: PREG=0, d: only P/CYI registered, e: all bypass
  dsp_post_stage u_a (.CLK(CLK), .RST(RST), .CEM(CEM), .CEP(CEP), .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
    .OPMODE(OPMODE), .M_IN(M_IN), .CONCAT(CONCAT), .C_IN(C_IN), .PCIN(PCIN), .CARRYIN(CARRYIN),
    .M(m[0]), .P(p[0]), .PCOUT(pc[0]), .CARRYOUT(co[0]), .CARRYOUTF(cof[0]));
  dsp_post_stage #(.CARRYINSEL("CARRYIN")) u_b (.CLK(CLK), .RST(RST), .CEM(CEM), .CEP(CEP),
    .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE), .OPMODE(OPMODE), .M_IN(M_IN), .CONCAT(CONCAT), .C_IN(C_IN),
    .PCIN(PCIN), .CARRYIN(CARRYIN), .M(m[1]), .P(p[1]), .PCOUT(pc[1]), .CARRYOUT(co[1]), .CARRYOUTF(cof[1]));
  dsp_post_stage #(.PREG(0)) u_c (.CLK(CLK), .RST(RST), .CEM(CEM), .CEP(CEP), .CECARRYIN(CECARRYIN),
    .CEOPMODE(CEOPMODE), .OPMODE(OPMODE), .M_IN(M_IN), .CONCAT(CONCAT), .C_IN(C_IN), .PCIN(PCIN),
    .CARRYIN(CARRYIN), .M(m[2]), .P(p[2]), .PCOUT(pc[2]), .CARRYOUT(co[2]), .CARRYOUTF(cof[2]));
  dsp_post_stage #(.MREG(0), .OPMODEREG(0)) u_d (.CLK(CLK), .RST(RST), .CEM(CEM), .CEP(CEP),
    .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE), .OPMODE(OPMODE), .M_IN(M_IN), .CONCAT(CONCAT), .C_IN(C_IN),
    .PCIN(PCIN), .CARRYIN(CARRYIN), .M(m[3]), .P(p[3]), .PCOUT(pc[3]), .CARRYOUT(co[3]), .CARRYOUTF(cof[3]));
  dsp_post_stage #(.MREG(0), .PREG(0), .CARRYINREG(0), .OPMODEREG(0)) u_e (.CLK(CLK), .RST(RST), .CEM(CEM),
    .CEP(CEP), .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE), .OPMODE(OPMODE), .M_IN(M_IN), .CONCAT(CONCAT),
    .C_IN(C_IN), .PCIN(PCIN), .CARRYIN(CARRYIN), .M(m[4]), .P(p[4]), .PCOUT(pc[4]), .CARRYOUT(co[4]),
    .CARRYOUTF(cof[4]));
  task automatic chk(input string nm, input int k, input logic [47:0] ep, input logic eco);
    n++;
    if (p[k] !== ep || pc[k] !== ep || co[k] !== eco || cof[k] !== eco) begin
      err++;
      $display("FAIL %s: P=%h PCOUT=%h CO=%b COF=%b, want P=%h CO=%b", nm, p[k], pc[k], co[k], cof[k], ep, eco);
    end
  endtask
  task automatic chk_m(input string nm, input int k, input logic [35:0] em);
    n++;
    if (m[k] !== em) begin
      err++;
      $display("FAIL %s: M=%h, want %h", nm, m[k], em);
    end
  endtask
  task automatic step(input int c);
    for (int i = 0; i < c; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask
  initial begin
    tbl[0] = '{8'h01, 36'd1000, 48'd0, 48'd0, 48'd0, 1'b0, 48'd1000, 1'b0};
    tbl[1] = '{8'h0D, 36'd3, 48'd5, 48'd0, 48'd0, 1'b0, 48'd8, 1'b0};
    tbl[2] = '{8'h8D, 36'd3, 48'd5, 48'd0, 48'd0, 1'b0, 48'd2, 1'b0};
    tbl[3] = '{8'h8D, 36'd6, 48'd5, 48'd0, 48'd0, 1'b0, 48'hFFFF_FFFF_FFFF, 1'b1};
    tbl[4] = '{8'h2C, 36'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 48'd0, 1'b0, 48'd0, 1'b1};
    tbl[5] = '{8'h07, 36'd0, 48'd0, 48'h10, 48'h20, 1'b0, 48'h30, 1'b0};
    tbl[6] = '{8'h0A, 36'd7, 48'd9, 48'd9, 48'd9, 1'b0, 48'd0, 1'b0};
    tbl[7] = '{8'hA0, 36'd0, 48'd0, 48'd0, 48'd0, 1'b0, 48'hFFFF_FFFF_FFFF, 1'b1};
    tbl[8] = '{8'h0F, 36'd0, 48'h8000_0000_0000, 48'h8000_0000_0000, 48'd0, 1'b0, 48'd0, 1'b1};
    tbl[9] = '{8'h04, 36'd0, 48'd0, 48'd0, 48'd123, 1'b0, 48'd123, 1'b0};
    foreach (tbl[i]) begin
      OPMODE = tbl[i].op;
      M_IN = tbl[i].mi;
      C_IN = tbl[i].c;
      CONCAT = tbl[i].cc;
      PCIN = tbl[i].pci;
      #1;
      chk($sformatf("bypass_vec%0d", i), 4, tbl[i].ep, tbl[i].eco);
    end
    // Full pipeline: reset with CEM high, then M at +1 edge and P at +2 edges.
    OPMODE = 8'h00; M_IN = 36'd1000; C_IN = 0; CONCAT = 0; PCIN = 0; RST = 1;
    step(2);
    chk("rst_p", 0, 48'd0, 1'b0);
    chk_m("rst_m", 0, 36'd0);
    RST = 0; OPMODE = 8'h01;
    step(1);
    chk("lat1", 0, 48'd0, 1'b0);
    chk_m("m_lat1", 0, 36'd1000);
    step(1);
    chk("lat2", 0, 48'd1000, 1'b0);
    OPMODE = 8'h0D; C_IN = 48'd5; M_IN = 36'd3;
    step(3);
    chk("add_m_c", 0, 48'd8, 1'b0);
    OPMODE = 8'h8D;
    step(3);
    chk("sub_m_c", 0, 48'd2, 1'b0);
    M_IN = 36'd6;
    step(3);
    chk("borrow", 0, 48'hFFFF_FFFF_FFFF, 1'b1);
    OPMODE = 8'h2C; C_IN = 48'hFFFF_FFFF_FFFF;
    step(3);
    chk("wrap", 0, 48'd0, 1'b1);
    OPMODE = 8'h03; CONCAT = 48'h10; CARRYIN = 1; C_IN = 0;
    step(3);
    chk("cyin_port", 1, 48'h11, 1'b0);
    chk("cyin_opmode5", 0, 48'h10, 1'b0);
    CARRYIN = 0; OPMODE = 8'h0A;
    step(3);
    chk("preg0_pfb", 2, 48'd0, 1'b0);
    // Accumulator with only P (and CYI) registered so each CEP edge adds M_IN.
    OPMODE = 8'h09; M_IN = 36'd10; RST = 1;
    step(1);
    chk("acc_rst", 3, 48'd0, 1'b0);
    RST = 0;
    for (int i = 1; i <= 5; i++) begin
      step(1);
      chk($sformatf("acc%0d", i), 3, 48'(10 * i), 1'b0);
    end
    CEP = 0;
    for (int i = 0; i < 2; i++) begin
      step(1);
      chk($sformatf("acc_hold%0d", i), 3, 48'd50, 1'b0);
    end
    CEP = 1; RST = 1;
    step(1);
    chk("acc_rst_wins", 3, 48'd0, 1'b0);
    RST = 0;
    step(1);
    chk("acc_restart", 3, 48'd10, 1'b0);
    chk("preg0_m_only", 2, 48'd10, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule
